sha1_block_sequencer: RTL

Sequences the SHA-1 core through its 8-bit-address / 32-bit-data register port so that a streaming requester can hash 512-bit blocks without software involvement. It accepts 16 message words over a valid/ready stream, writes them into the core, issues init or next, polls the core's ready flag, then streams the 5 digest words out. It sits between the block-feeding logic (or the Nios PIO bridge) and the sha1 core's `address`/`write_data`/`read_data`/`cs`/`we` port.

---
 rtl/sha1_block_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sha1_block_sequencer.sv
// sha1_block_sequencer
// Drives a SHA-1 core through its 8-bit address / 32-bit data register port:
// accepts 16 message words on a valid/ready stream, writes them to the core's
// BLOCK registers, issues init or next, polls STATUS.ready, then streams the
// five digest words out (H0 first, out_last on H4).
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   start, first          : block start pulse; first=1 selects init, 0 next
//   in_valid/in_ready/in_data           : message word stream (word 0 = bits 511:480)
//   out_valid/out_ready/out_data/out_last : digest word stream
//   busy, timeout         : block in progress; sticky poll-limit flag
//   core_cs/core_we/core_address/core_write_data/core_read_data : core register port
module sha1_block_sequencer #(
    parameter int unsigned POLL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        first,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        timeout,
    output logic        core_cs,
    output logic        core_we,
    output logic [7:0]  core_address,
    output logic [31:0] core_write_data,
    input  logic [31:0] core_read_data
);

    localparam int unsigned PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_BLOCK  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST = 8'h20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CMD    = 3'd2,
        POLL   = 3'd3,
        DIGEST = 3'd4,
        OUT    = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [PW-1:0] poll_cnt, poll_cnt_nxt;
    logic          first_q, first_nxt;
    logic          timeout_q, timeout_nxt;
    logic [31:0]   out_data_q, out_data_nxt;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            poll_cnt   <= '0;
            first_q    <= 1'b0;
            timeout_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            poll_cnt   <= poll_cnt_nxt;
            first_q    <= first_nxt;
            timeout_q  <= timeout_nxt;
            out_data_q <= out_data_nxt;
        end
    end

    // Next-state, counter updates and core-port / stream decode
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        poll_cnt_nxt    = poll_cnt;
        first_nxt       = first_q;
        timeout_nxt     = timeout_q;
        out_data_nxt    = out_data_q;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        core_cs         = 1'b0;
        core_we         = 1'b0;
        core_address    = '0;
        core_write_data = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    first_nxt   = first;
                    timeout_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_cs         = 1'b1;
                    core_we         = 1'b1;
                    core_address    = ADDR_BLOCK + 8'(cnt);
                    core_write_data = in_data;
                    cnt_nxt         = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state_nxt = CMD;
                    end
                end
            end
            CMD: begin
                core_cs         = 1'b1;
                core_we         = 1'b1;
                core_address    = ADDR_CTRL;
                core_write_data = first_q ? 32'h1 : 32'h2;
                poll_cnt_nxt    = '0;
                state_nxt       = POLL;
            end
            POLL: begin
                core_cs      = 1'b1;
                core_address = ADDR_STATUS;
                if (core_read_data[0]) begin
                    cnt_nxt   = '0;
                    state_nxt = DIGEST;
                end else if (poll_cnt == POLL_LAST) begin
                    // This was the POLL_LIMIT-th unsuccessful read
                    timeout_nxt = 1'b1;
                    state_nxt   = ERR;
                end else begin
                    poll_cnt_nxt = poll_cnt + PW'(1);
                end
            end
            DIGEST: begin
                core_cs      = 1'b1;
                core_address = ADDR_DIGEST + 8'(cnt);
                out_data_nxt = core_read_data;
                state_nxt    = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = (cnt == 4'd4);
                if (out_ready) begin
                    if (cnt == 4'd4) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = cnt + 4'd1;
                        state_nxt = DIGEST;
                    end
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign timeout  = timeout_q;
    assign out_data = out_data_q;

endmodule
